adder_token_dispatcher: RTL

- Upstream driver and downstream collector for adder_module, the far end of its entry/add/result/show_result interface.
- Joins one token from each of two KPN operand channels (valid/ready) and presents the pair on entry_1/entry_2 with add asserted low.
- Captures result while show_result is high and queues the sum into an output FIFO that feeds the next KPN channel.
- Turns the purely combinational adder into a flow-controlled KPN process node.

---
 rtl/adder_token_dispatcher.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/adder_token_dispatcher.sv
// -----------------------------------------------------------------------------
// adder_token_dispatcher
//
// Wraps the purely combinational adder_module and turns it into a
// flow-controlled KPN process node. It drives entry_1/entry_2/add and collects
// result/show_result.
//
// Operation:
//   - Strict join: one token is taken from each operand channel in the same
//     cycle, or no token is taken from either.
//   - The operand pair is held on entry_1/entry_2 while add is driven low.
//   - When show_result is high, result is pushed into a small circular output
//     FIFO. The FIFO head feeds the next KPN channel.
//
// Ports:
//   clk, reset           single clock; synchronous active-high reset
//   in1_* / in2_*        operand channels (valid/ready)
//   entry_1, entry_2     operands to the adder
//   add                  active-low add request to the adder
//   result, show_result  sum from the adder and its valid flag
//   out_data, out_valid  sum channel to the consumer (FIFO head)
//   out_ready            consumer accepts the head token
//   busy                 an add is in flight, or sums are queued
//
// Optional feature, enabled by defining ADDER_OVERFLOW_FLAG_EN:
//   out_overflow  carry out of entry_1 + entry_2. It is stored with each
//                 queued sum and is valid together with out_data.
// -----------------------------------------------------------------------------
module adder_token_dispatcher #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [DATA_WIDTH-1:0] in2_data,
  input  logic                  in2_valid,
  output logic                  in2_ready,
  output logic [DATA_WIDTH-1:0] entry_1,
  output logic [DATA_WIDTH-1:0] entry_2,
  output logic                  add,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  show_result,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef ADDER_OVERFLOW_FLAG_EN
  output logic                  out_overflow,
`endif
  output logic                  busy
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t state, state_next;

  logic             join_ok;
  logic             join_pop;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic [DATA_WIDTH-1:0] sum_mem [OUT_DEPTH];

  // A new pair is admitted only when a FIFO slot is free at that moment.
  // Between admission and the push, the FIFO can only be popped, so the
  // reserved slot cannot be lost and the push can never overflow.
  assign join_ok = in1_valid && in2_valid && (fifo_count < CNT_W'(OUT_DEPTH));

  // NOTE: every output of this block gets a default first, so no path through
  //       the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    add        = 1'b1;
    in1_ready  = 1'b0;
    in2_ready  = 1'b0;
    join_pop   = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        in1_ready = join_ok;
        in2_ready = join_ok;
        join_pop  = join_ok;
        if (join_ok) state_next = ISSUE;
      end
      ISSUE: begin
        // Hold the request and the operands until the adder reports a result.
        add = 1'b0;
        if (show_result) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments, so
  //       every flop samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The operands keep their last values after ISSUE. They change only when a
  // new pair is joined.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_1 <= '0;
      entry_2 <= '0;
    end else if (join_pop) begin
      entry_1 <= in1_data;
      entry_2 <= in2_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;  // a pop while empty is ignored

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      // OUT_DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;  // idle, or a push and pop together
      endcase
    end
  end

  // NOTE: the storage array has no reset. Clearing the pointers already empties
  //       the FIFO, and out_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) sum_mem[wr_ptr] <= result;
  end

  assign out_data = out_valid ? sum_mem[rd_ptr] : '0;

`ifdef ADDER_OVERFLOW_FLAG_EN
  logic [DATA_WIDTH:0] wide_sum;
  logic                ovf_mem [OUT_DEPTH];

  // The carry is recomputed from the held operands and is not taken from the
  // adder, which only provides the truncated sum.
  assign wide_sum = {1'b0, entry_1} + {1'b0, entry_2};

  always_ff @(posedge clk) begin
    if (push && !reset) ovf_mem[wr_ptr] <= wide_sum[DATA_WIDTH];
  end

  assign out_overflow = out_valid ? ovf_mem[rd_ptr] : 1'b0;
`endif

  assign busy = (state == ISSUE) || out_valid;

endmodule
